// File: rtl/brisc_pkg.sv
// Shared BRISC execute-stage definitions: widths, ALU opcodes, top FSM states.
package brisc_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned OP_W   = 3;

  localparam logic [OP_W-1:0] ALU_ADD = OP_W'(0);
  localparam logic [OP_W-1:0] ALU_SUB = OP_W'(1);
  localparam logic [OP_W-1:0] ALU_AND = OP_W'(2);
  localparam logic [OP_W-1:0] ALU_OR  = OP_W'(3);
  localparam logic [OP_W-1:0] ALU_XOR = OP_W'(4);
  localparam logic [OP_W-1:0] ALU_SHL = OP_W'(5);
  localparam logic [OP_W-1:0] ALU_SHR = OP_W'(6);
  localparam logic [OP_W-1:0] ALU_MUL = OP_W'(7);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_e;

endpackage

// File: rtl/seq_mul_core.sv
// Iterative shift-add unsigned multiplier: one multiplier bit per cycle.
// done is a combinational strobe during the final iteration; product and
// overflow reflect the accumulator value being written on that edge.
module seq_mul_core
  import brisc_pkg::*;
#(
  parameter int unsigned DATA_W = brisc_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product,
  output logic              overflow
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [DATA_W-1:0]   mcand_q, mcand_d;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                busy_q, busy_d;
  logic                last;
  logic [2*DATA_W-1:0] partial;

  // Next-state: launch when idle, otherwise run one shift-add iteration
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    busy_d   = busy_q;
    last     = 1'b0;
    partial  = {{DATA_W{1'b0}}, mcand_q} << count_q;
    if (!busy_q) begin
      if (start) begin
        mcand_d  = a;
        mplier_d = b;
        acc_d    = '0;
        count_d  = '0;
        busy_d   = 1'b1;
      end
    end else begin
      if (mplier_q[0]) begin
        acc_d = acc_q + partial;
      end
      mplier_d = mplier_q >> 1;
      count_d  = count_q + CNT_W'(1);
      if (count_q == CNT_W'(DATA_W - 1)) begin
        busy_d = 1'b0;
        last   = 1'b1;
      end
    end
  end

  // Multiplier state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign done     = last;
  assign product  = acc_d[DATA_W-1:0];
  assign overflow = |acc_d[2*DATA_W-1:DATA_W];

endmodule

// File: rtl/seq_alu.sv
// BRISC execute stage: single-cycle logic/add/shift ops plus an iterative MUL,
// with registered result, flags and a one-cycle done pulse.
module seq_alu
  import brisc_pkg::*;
#(
  parameter int unsigned DATA_W = brisc_pkg::DATA_W,
  parameter int unsigned OP_W   = brisc_pkg::OP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              carry,
  output logic              negative,
  output logic              busy,
  output logic              done
);

  alu_state_e state_q, state_d;

  logic              mul_start, alu_capture;
  logic              mul_busy, mul_done, mul_ovf;
  logic [DATA_W-1:0] mul_prod;

  logic [DATA_W-1:0] alu_res;
  logic              alu_carry;
  logic [DATA_W:0]   wide;
  logic [3:0]        sh;

  logic [DATA_W-1:0] result_q;
  logic              zero_q, carry_q, neg_q, done_q;

  seq_mul_core #(
    .DATA_W(DATA_W)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (operand_a),
    .b       (operand_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod),
    .overflow(mul_ovf)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: only MUL leaves IDLE; the core's final iteration returns
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start && alu_op == ALU_MUL) state_d = ST_MUL;
      ST_MUL:  if (mul_done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: start is honoured only in IDLE, so pulses while busy are dropped
  always_comb begin
    mul_start   = (state_q == ST_IDLE) && start && (alu_op == ALU_MUL);
    alu_capture = (state_q == ST_IDLE) && start && (alu_op != ALU_MUL);
  end

  // Single-cycle op decode; shifts use a one-bit guard so the bit shifted
  // out lands in a fixed position and a zero shift naturally yields carry=0
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    wide      = '0;
    sh        = operand_b[3:0];
    case (alu_op)
      ALU_ADD: begin
        wide      = {1'b0, operand_a} + {1'b0, operand_b};
        alu_res   = wide[DATA_W-1:0];
        alu_carry = wide[DATA_W];
      end
      ALU_SUB: begin
        wide      = {1'b0, operand_a} - {1'b0, operand_b};
        alu_res   = wide[DATA_W-1:0];
        alu_carry = wide[DATA_W];
      end
      ALU_AND: alu_res = operand_a & operand_b;
      ALU_OR:  alu_res = operand_a | operand_b;
      ALU_XOR: alu_res = operand_a ^ operand_b;
      ALU_SHL: begin
        wide      = {1'b0, operand_a} << sh;
        alu_res   = wide[DATA_W-1:0];
        alu_carry = wide[DATA_W];
      end
      ALU_SHR: begin
        wide      = {operand_a, 1'b0} >> sh;
        alu_res   = wide[DATA_W:1];
        alu_carry = wide[0];
      end
      default: begin
        alu_res   = '0;
        alu_carry = 1'b0;
      end
    endcase
  end

  // Result/flag registers: updated only on a completing op, held otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      neg_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= alu_capture || mul_done;
      if (alu_capture) begin
        result_q <= alu_res;
        carry_q  <= alu_carry;
        zero_q   <= (alu_res == '0);
        neg_q    <= alu_res[DATA_W-1];
      end else if (mul_done) begin
        result_q <= mul_prod;
        carry_q  <= mul_ovf;
        zero_q   <= (mul_prod == '0);
        neg_q    <= mul_prod[DATA_W-1];
      end
    end
  end

  assign result   = result_q;
  assign zero     = zero_q;
  assign carry    = carry_q;
  assign negative = neg_q;
  assign busy     = mul_busy;
  assign done     = done_q;

endmodule
